// File: rtl/layer_sequencer.sv
// layer_sequencer
// ---------------
// Sequences one frame through a fully connected neural layer:
//   IDLE  -> waits for start
//   FEED  -> accepts numWeight activations from upstream and broadcasts each
//            one (registered, one cycle later) to every neuron
//   WAIT  -> collects one result per neuron from its output strobe
//   DRAIN -> serializes the collected results, neuron 0 first, downstream
// and then returns to IDLE with a one-cycle done pulse.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Valid/data never depend on ready. in_ready is high only in
// FEED; out_valid is high only in DRAIN, and out_data holds until the
// transfer completes.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin a frame (only looked at in IDLE)
//   in_data/in_valid/in_ready   upstream activation stream
//   myinput/myinputValid        activation broadcast to the neurons
//   n_out/n_outvalid            packed neuron results and per-neuron strobes
//   out_data/out_valid/out_ready downstream result stream
//   busy              high whenever not IDLE
//   done              one-cycle pulse on the first IDLE cycle after a frame
//   state_dbg         current FSM state (IDLE=0, FEED=1, WAIT=2, DRAIN=3)
module layer_sequencer #(
    parameter int numWeight  = 784,
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [dataWidth-1:0]             in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [dataWidth-1:0]             myinput,
    output logic                             myinputValid,
    input  logic [numNeurons*dataWidth-1:0]  n_out,
    input  logic [numNeurons-1:0]            n_outvalid,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             done,
    output logic [1:0]                       state_dbg
);

    localparam int CW = $clog2(numWeight + 1);
    localparam int KW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(numWeight - 1);
    localparam logic [KW-1:0] LAST_K    = KW'(numNeurons - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           in_cnt;
    logic [numNeurons-1:0]   mask;
    logic [numNeurons-1:0]   capture;
    logic [KW-1:0]           k;
    logic [dataWidth-1:0]    result [numNeurons];
    logic                    beat_accept;
    logic                    out_fire;

    assign state_dbg = state;

    // A strobe is taken only in WAIT and only for a neuron not yet captured,
    // so a repeated strobe can never overwrite the first value of a frame.
    assign capture = (state == WAIT) ? (n_outvalid & ~mask) : '0;

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        beat_accept = 1'b0;
        out_fire    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = FEED;
            end
            FEED: begin
                in_ready    = 1'b1;
                beat_accept = in_valid;
                // The beat that makes the count numWeight is the last one;
                // in_ready is gone the following cycle.
                if (in_valid && (in_cnt == LAST_BEAT)) state_next = WAIT;
            end
            WAIT: begin
                // Registered mask: DRAIN starts the cycle after it fills.
                if (&mask) state_next = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_fire  = out_ready;
                if (out_ready && (k == LAST_K)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Control registers and broadcast register.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt       <= '0;
            mask         <= '0;
            k            <= '0;
            myinput      <= '0;
            myinputValid <= 1'b0;
            done         <= 1'b0;
        end else begin
            myinputValid <= beat_accept;
            done         <= 1'b0;
            if (beat_accept) myinput <= in_data;
            case (state)
                IDLE: begin
                    if (start) begin
                        in_cnt <= '0;
                        mask   <= '0;
                        k      <= '0;
                    end
                end
                FEED: begin
                    if (beat_accept) in_cnt <= in_cnt + CW'(1);
                end
                WAIT: begin
                    mask <= mask | capture;
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (k == LAST_K) done <= 1'b1;
                        else             k    <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers keep their contents until the next frame captures.
    always_ff @(posedge clk) begin
        for (int i = 0; i < numNeurons; i++) begin
            if (capture[i]) result[i] <= n_out[i*dataWidth +: dataWidth];
        end
    end

    assign out_data = (state == DRAIN) ? result[k] : '0;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with numWeight=4, numNeurons=3,
// dataWidth=16. Inputs are driven and outputs sampled on the falling edge.
module tb_layer_sequencer;

    localparam int NW = 4;
    localparam int NN = 3;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   myinput;
    logic            myinputValid;
    logic [NN*DW-1:0] n_out;
    logic [NN-1:0]   n_outvalid;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            done;
    logic [1:0]      state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    layer_sequencer #(.numWeight(NW), .numNeurons(NN), .dataWidth(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .myinput      (myinput),
        .myinputValid (myinputValid),
        .n_out        (n_out),
        .n_outvalid   (n_outvalid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // Feeds four beats d[15:0], d[31:16], ... Optional gap of gap_len idle
    // cycles before beat gap_at; optional start pulses during the gap;
    // optional junk neuron strobes during FEED (must be ignored).
    task automatic feed(input logic [4*DW-1:0] d, input logic do_start, input int gap_at,
                        input int gap_len, input logic start_in_gap, input logic junk);
        int idx = 0;
        int gap = 0;
        int guard = 0;
        int bc = 0;
        logic prev_acc = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] last;
        last = d[3*DW +: DW];
        if (do_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        while (idx < NW && guard < 40) begin
            @(negedge clk);
            guard++;
            start = 1'b0;
            tests_run++;
            if (myinputValid !== prev_acc) begin
                tests_failed++;
                $display("FAIL feed_bcast_valid: got %b expected %b (beat %0d)", myinputValid, prev_acc, idx);
            end
            if (prev_acc) begin
                bc++;
                tests_run++;
                if (myinput !== prev_data) begin
                    tests_failed++;
                    $display("FAIL feed_bcast_data: got %h expected %h", myinput, prev_data);
                end
            end
            tests_run++;
            if (in_ready !== 1'b1 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL feed_ready: got in_ready=%b busy=%b expected 1 1", in_ready, busy);
            end
            n_outvalid = junk ? '1 : '0;
            n_out      = junk ? {NN{16'hDEAD}} : '0;
            if (idx == gap_at && gap < gap_len) begin
                in_valid = 1'b0;
                start    = start_in_gap;
                gap++;
                prev_acc = 1'b0;
            end else begin
                in_valid  = 1'b1;
                in_data   = d[idx*DW +: DW];
                prev_acc  = 1'b1;
                prev_data = d[idx*DW +: DW];
                idx++;
            end
        end
        tests_run++;
        if (idx != NW) begin
            tests_failed++;
            $display("FAIL feed_timeout: got %0d beats expected %0d", idx, NW);
        end
        @(negedge clk);
        n_outvalid = '0;
        in_valid   = 1'b0;
        start      = 1'b0;
        if (myinputValid === 1'b1) bc++;
        tests_run++;
        if (myinputValid !== 1'b1 || myinput !== last) begin
            tests_failed++;
            $display("FAIL feed_last_bcast: got v=%b d=%h expected v=1 d=%h", myinputValid, myinput, last);
        end
        tests_run++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || state_dbg !== 2'd2) begin
            tests_failed++;
            $display("FAIL feed_enter_wait: got in_ready=%b busy=%b state=%0d expected 0 1 2", in_ready, busy, state_dbg);
        end
        // Keep in_valid high in WAIT: no fifth beat may be taken.
        in_valid = 1'b1;
        in_data  = 16'h5555;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (myinputValid !== 1'b0 || myinput !== last || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL feed_hold: got v=%b d=%h out_valid=%b expected v=0 d=%h out_valid=0", myinputValid, myinput, out_valid, last);
        end
        tests_run++;
        if (bc != NW) begin
            tests_failed++;
            $display("FAIL feed_bcast_count: got %0d expected %0d", bc, NW);
        end
    endtask

    // One cycle of neuron strobes, then strobes low again.
    task automatic strobe(input logic [NN-1:0] v, input logic [NN*DW-1:0] data);
        @(negedge clk);
        n_outvalid = v;
        n_out      = data;
        @(negedge clk);
        n_outvalid = '0;
        n_out      = '0;
    endtask

    // Waits for DRAIN, stalls index 0 for 'stall' cycles, then takes all
    // three results in order and checks the done pulse.
    task automatic drain(input logic [NN*DW-1:0] exp_v, input int stall, input logic restart);
        int guard = 0;
        logic [DW-1:0] e;
        while (out_valid !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_timeout: got out_valid=%b expected 1", out_valid);
        end
        for (int i = 0; i < NN; i++) begin
            e = exp_v[i*DW +: DW];
            if (i == 0) begin
                for (int s = 0; s < stall; s++) begin
                    out_ready = 1'b0;
                    tests_run++;
                    if (out_valid !== 1'b1 || out_data !== e || done !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL drain_stall: got v=%b d=%h done=%b expected v=1 d=%h done=0", out_valid, out_data, done, e);
                    end
                    @(negedge clk);
                end
            end
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== e || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL drain_data[%0d]: got v=%b d=%h done=%b expected v=1 d=%h done=0", i, out_valid, out_data, done, e);
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL drain_done: got done=%b busy=%b out_valid=%b state=%0d expected 1 0 0 0", done, busy, out_valid, state_dbg);
        end
        if (restart) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (done !== 1'b0 || busy !== restart || in_ready !== restart) begin
            tests_failed++;
            $display("FAIL drain_after_done: got done=%b busy=%b in_ready=%b expected 0 %b %b", done, busy, in_ready, restart, restart);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if (myinput !== '0 || myinputValid !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== '0 || done !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL %s: got mi=%h miv=%b ir=%b ov=%b od=%h done=%b busy=%b st=%0d expected all 0",
                     tag, myinput, myinputValid, in_ready, out_valid, out_data, done, busy, state_dbg);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0;
        n_out = '0; n_outvalid = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    // Continuous feed 1,2,3,4 with junk strobes in FEED; WAIT strobes:
    // neuron 2 alone, then neurons 0 and 1 together.
    task automatic test_basic();
        feed({16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, -1, 0, 1'b0, 1'b1);
        strobe(3'b100, {16'h0A00, 16'h0000, 16'h0000});
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_pending: got out_valid=%b busy=%b expected 0 1", out_valid, busy);
        end
        strobe(3'b011, {16'h0000, 16'h0200, 16'h0100});
        drain({16'h0A00, 16'h0200, 16'h0100}, 0, 1'b0);
    endtask

    // Gap of 5 before beat 3 with start pulsed in the gap; duplicate strobe
    // on neuron 0; downstream stalls 3 cycles on index 0.
    task automatic test_stall();
        feed({16'h0044, 16'h0033, 16'h0022, 16'h0011}, 1'b1, 2, 5, 1'b1, 1'b0);
        strobe(3'b001, {16'h0000, 16'h0000, 16'h0100});
        strobe(3'b001, {16'h0000, 16'h0000, 16'hFFFF});
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_pending: got out_valid=%b expected 0", out_valid);
        end
        strobe(3'b110, {16'h0A00, 16'h0200, 16'h0000});
        drain({16'h0A00, 16'h0200, 16'h0100}, 3, 1'b0);
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL start_not_queued: got busy=%b done=%b expected 0 0", busy, done);
            end
        end
    endtask

    // Start on the done cycle launches the next frame immediately.
    task automatic test_back_to_back();
        feed({16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, -1, 0, 1'b0, 1'b0);
        strobe(3'b111, {16'h3333, 16'h2222, 16'h1111});
        drain({16'h3333, 16'h2222, 16'h1111}, 0, 1'b1);
        feed({16'd12, 16'd11, 16'd10, 16'd9}, 1'b0, -1, 0, 1'b0, 1'b0);
        strobe(3'b010, {16'h0000, 16'hBEEF, 16'h0000});
        strobe(3'b101, {16'hC0DE, 16'h0000, 16'h1234});
        drain({16'hC0DE, 16'hBEEF, 16'h1234}, 1, 1'b0);
    endtask

    // Reset in WAIT with one of three neurons captured, then a clean frame.
    task automatic test_abort();
        feed({16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1}, 1'b1, -1, 0, 1'b0, 1'b0);
        strobe(3'b010, {16'h0000, 16'h0200, 16'h0000});
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort_reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort_idle");
        feed({16'h0B04, 16'h0B03, 16'h0B02, 16'h0B01}, 1'b1, -1, 0, 1'b0, 1'b0);
        strobe(3'b001, {16'h0000, 16'h0000, 16'h0707});
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_mask_cleared: got out_valid=%b expected 0", out_valid);
        end
        strobe(3'b110, {16'h0909, 16'h0808, 16'h0000});
        drain({16'h0909, 16'h0808, 16'h0707}, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter numWeight, default 784: input activations per frame, equal to each neuron's weight count.
REQ-002 Parameter numNeurons, default 30: neurons in the layer driven by this sequencer.
REQ-003 Parameter dataWidth, default 16: activation width.
REQ-004 Port clk, input, 1: single clock; all logic on posedge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: begin one frame; honoured only in IDLE.
REQ-007 Port in_data, input, dataWidth: upstream activation.
REQ-008 Port in_valid / in_ready, input / output, 1 each: upstream handshake; a beat transfers when both are high.
REQ-009 Port myinput, output, dataWidth: activation broadcast to all neurons.
REQ-010 Port myinputValid, output, 1: broadcast qualifier.
REQ-011 Port n_out, input, numNeurons*dataWidth: neuron outputs; neuron i is at bits [i*dataWidth +: dataWidth].
REQ-012 Port n_outvalid, input, numNeurons: per-neuron one-cycle output strobe.
REQ-013 Port out_data, output, dataWidth: serialized layer result.
REQ-014 Ports out_valid / out_ready, output / input, 1 each: downstream handshake.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse at frame end.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, FEED, WAIT and DRAIN.
REQ-018 IDLE: start=1 SHALL move the FSM to FEED and clear the input counter, the capture mask and the drain index.
REQ-019 FEED: in_ready SHALL be 1; otherwise in_ready SHALL be 0.
REQ-020 On each accepted beat, myinput SHALL take in_data and myinputValid SHALL be 1 on the next cycle (registered, latency 1); otherwise myinputValid SHALL be 0 and myinput SHALL hold.
REQ-021 in_valid low in FEED SHALL stall without loss; gaps of any length are legal.
REQ-022 Input counter width SHALL be $clog2(numWeight+1).
REQ-023 The beat that brings the count to numWeight SHALL be the last one accepted; the FSM SHALL enter WAIT on the next cycle, and no beat numWeight+1 SHALL be accepted.
REQ-024 WAIT: when n_outvalid[i]=1, the sequencer SHALL capture n_out slice i into result register i and set mask bit i.
REQ-025 Strobes for already-captured neurons SHALL be ignored.
REQ-026 n_outvalid SHALL be ignored in IDLE, FEED and DRAIN.
REQ-027 Strobes from several neurons in the same cycle SHALL all be captured.
REQ-028 The FSM SHALL enter DRAIN on the cycle after the mask becomes all ones.
REQ-029 DRAIN: out_valid SHALL be 1 and out_data SHALL equal result register k, with k starting at 0.
REQ-030 k SHALL increment only when out_valid & out_ready.
REQ-031 out_data SHALL be stable while out_ready is low.
REQ-032 The handshake with k=numNeurons-1 SHALL return the FSM to IDLE and pulse done for one cycle, coincident with the first IDLE cycle.
REQ-033 start asserted outside IDLE SHALL be ignored and not queued.
REQ-034 start on the IDLE cycle carrying done SHALL start a new frame.
REQ-035 Result registers SHALL hold their values until overwritten by the next frame's captures.

Reset
REQ-036 rst SHALL override all other inputs in the cycle it is sampled.
REQ-037 Reset values: state=IDLE; input counter, mask and k = 0; myinputValid, in_ready, out_valid, done and busy = 0; myinput and out_data = 0.
REQ-038 rst asserted mid-FEED, mid-WAIT or mid-DRAIN SHALL abort the frame; the next start SHALL begin a clean frame.
REQ-039 After an abort, the user SHALL reset the neurons too; the sequencer does not track neuron state.

Verification
REQ-040 numWeight=4, numNeurons=3, continuous in_valid with data 1,2,3,4: myinputValid high for 4 cycles, each 1 cycle after acceptance; in_ready drops after beat 4.
REQ-041 Same setup with in_valid low for 5 cycles between beats 2 and 3: exactly 4 broadcasts, no duplicates, correct order.
REQ-042 Strobes in WAIT: neuron 2 (0x0A00), then neurons 0 and 1 together (0x0100, 0x0200) -> DRAIN outputs 0x0100, 0x0200, 0x0A00 in that order.
REQ-043 A duplicate strobe on neuron 0 (0xFFFF) after its first capture, while other neurons are still pending -> drain still outputs the first-captured value 0x0100.
REQ-044 out_ready held low 3 cycles in DRAIN: out_data stable at index 0; done pulses once after the 3rd handshake; start pulsed during FEED has no effect.
REQ-045 rst in WAIT with 1 of 3 neurons captured -> all outputs return to reset values next cycle; a new frame then completes normally.
